// File: rtl/addsub_flag_stage.sv
// Result register stage behind the 4-bit adder: stores res plus N/Z/C/V and counts overflows.
// Latency 1 cycle; a 2-entry skid buffer absorbs consumer stalls, and in_ready depends only on occupancy.
module addsub_flag_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             op,
  input  logic [3:0]       sum,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       res,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  typedef struct packed {
    logic [3:0] res;
    logic       n;
    logic       z;
    logic       c;
    logic       v;
  } entry_t;

  localparam logic [1:0]       OCC_EMPTY = 2'd0;
  localparam logic [1:0]       OCC_ONE   = 2'd1;
  localparam logic [1:0]       OCC_FULL  = DEPTH[1:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  entry_t     entry0;
  entry_t     entry1;
  entry_t     new_entry;
  logic [1:0] occ;
  logic       push;
  logic       pop;

  // Only the sign bits of the operands feed the overflow flag.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{a[2:0], b[2:0]};

  assign in_ready  = (occ < OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flags are captured from the adder outputs as presented; sum is not recomputed.
  always_comb begin
    new_entry     = '0;
    new_entry.res = sum;
    new_entry.n   = sum[3];
    new_entry.z   = (sum == 4'd0);
    new_entry.c   = carry ^ op;
    new_entry.v   = (a[3] ~^ (b[3] ^ op)) & (sum[3] ^ a[3]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      occ    <= OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            entry0 <= new_entry;
            occ    <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            entry0 <= new_entry;
          end else if (push) begin
            entry1 <= new_entry;
            occ    <= OCC_FULL;
          end else if (pop) begin
            occ    <= OCC_EMPTY;
          end
        end
        default: begin
          if (pop) begin
            entry0 <= entry1;
            occ    <= OCC_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (push && new_entry.v && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign res    = entry0.res;
  assign flag_n = entry0.n;
  assign flag_z = entry0.z;
  assign flag_c = entry0.c;
  assign flag_v = entry0.v;

endmodule

// File: tb/tb_addsub_flag_stage.sv
// Randomized and directed bench for addsub_flag_stage against an arithmetic queue model.
module tb_addsub_flag_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       op = 1'b0;
  logic [3:0] sum = '0;
  logic       carry = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] res;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic [3:0] ovf_cnt;
  logic       cnt_clr = 1'b0;

  addsub_flag_stage #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sum(sum), .carry(carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int n;
    int z;
    int c;
    int v;
  } exp_t;

  exp_t q[$];
  int   model_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int to_signed4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Expected flags from the arithmetic meaning of the operation.
  function automatic exp_t model_beat(input int ia, input int ib, input int iop, input int isum);
    exp_t e;
    int   r;
    r     = iop ? to_signed4(ia) - to_signed4(ib) : to_signed4(ia) + to_signed4(ib);
    e.res = isum;
    e.n   = (isum >= 8) ? 1 : 0;
    e.z   = (isum == 0) ? 1 : 0;
    e.c   = iop ? ((ia < ib) ? 1 : 0) : ((ia + ib > 15) ? 1 : 0);
    e.v   = (r > 7 || r < -8) ? 1 : 0;
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, int'(out_valid), (q.size() > 0) ? 1 : 0);
    check({tag, ".in_ready"}, int'(in_ready), (q.size() < 2) ? 1 : 0);
    check({tag, ".ovf_cnt"}, int'(ovf_cnt), model_cnt);
    if (q.size() > 0) begin
      check({tag, ".res"}, int'(res), q[0].res);
      check({tag, ".n"}, int'(flag_n), q[0].n);
      check({tag, ".z"}, int'(flag_z), q[0].z);
      check({tag, ".c"}, int'(flag_c), q[0].c);
      check({tag, ".v"}, int'(flag_v), q[0].v);
    end
  endtask

  // Drives one cycle from a negedge, advances the model at the posedge, checks at the next negedge.
  task automatic step(input string tag, input int iv, input int ia, input int ib, input int iop,
                      input int ordy, input int clr);
    int   u;
    bit   do_push, do_pop;
    exp_t e;
    u         = iop ? ia + 16 - ib : ia + ib;
    in_valid  = iv[0];
    a         = ia[3:0];
    b         = ib[3:0];
    op        = iop[0];
    sum       = u[3:0];
    carry     = u[4];
    out_ready = ordy[0];
    cnt_clr   = clr[0];
    do_push   = (iv != 0) && (q.size() < 2);
    do_pop    = (q.size() > 0) && (ordy != 0);
    e         = model_beat(ia, ib, iop, u % 16);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    if (clr != 0) model_cnt = 0;
    else if (do_push && e.v == 1 && model_cnt < 15) model_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    #1;
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.res", int'(res), 0);
    check("rst.flags", int'({flag_n, flag_z, flag_c, flag_v}), 0);
    check("rst.ovf_cnt", int'(ovf_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel.in_ready", int'(in_ready), 1);
    @(negedge clk);

    // Directed cases with explicit expectations as well as model checks.
    step("add_ovf", 1, 5, 3, 0, 1, 0);
    check("add_ovf.res8", int'(res), 8);
    check("add_ovf.nzcv", int'({flag_n, flag_z, flag_c, flag_v}), 4'b1001);
    check("add_ovf.cnt1", int'(ovf_cnt), 1);
    step("sub_zero", 1, 3, 3, 1, 1, 0);
    check("sub_zero.nzcv", int'({flag_n, flag_z, flag_c, flag_v}), 4'b0100);
    step("sub_borrow", 1, 2, 5, 1, 1, 0);
    check("sub_borrow.res13", int'(res), 13);
    check("sub_borrow.nzcv", int'({flag_n, flag_z, flag_c, flag_v}), 4'b1010);
    step("sub_ovf", 1, 8, 1, 1, 1, 0);
    check("sub_ovf.cv", int'({flag_c, flag_v}), 2'b01);
    step("drain", 0, 0, 0, 0, 1, 0);

    // Backpressure: third beat must be refused.
    step("bp1", 1, 1, 0, 0, 0, 0);
    step("bp2", 1, 2, 0, 0, 0, 0);
    check("bp2.in_ready0", int'(in_ready), 0);
    step("bp3", 1, 3, 0, 0, 0, 0);
    check("bp3.stall_res", int'(res), 1);
    step("bp_pop1", 0, 0, 0, 0, 1, 0);
    check("bp_pop1.res2", int'(res), 2);
    check("bp_pop1.in_ready1", int'(in_ready), 1);
    step("bp_pop2", 0, 0, 0, 0, 1, 0);
    check("bp_pop2.empty", int'(out_valid), 0);

    // Counter saturation and clear priority.
    step("clr0", 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 17; i++) step("sat", 1, 5, 3, 0, 1, 0);
    check("sat.cnt15", int'(ovf_cnt), 15);
    step("clr_vs_inc", 1, 5, 3, 0, 1, 1);
    check("clr_vs_inc.cnt0", int'(ovf_cnt), 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 40) == 0) ? 1 : 0);
    end

    // Asynchronous reset while full.
    step("fill1", 1, 7, 7, 0, 0, 0);
    step("fill2", 1, 6, 4, 1, 0, 0);
    check("fill2.full", int'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("arst.out_valid", int'(out_valid), 0);
    check("arst.ovf_cnt", int'(ovf_cnt), 0);
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_rel.in_ready", int'(in_ready), 1);
    @(negedge clk);
    step("post_rst", 1, 4, 1, 0, 0, 0);
    check("post_rst.res5", int'(res), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
